accum_shift_ctrl: RTL and testbench

Sequencer for the 8-bit accumulator shift register. Accepts one accumulator operation per request from the control unit (load, clear, set, logical shift, rotate) and drives the register's clr/set/ctrl/num_shift/Ls/Rs inputs cycle by cycle. Every shift runs as one single-bit step per clock so rotate fill bits can be taken from the live register output. Sits between the instruction decoder and the accumulator register.

---
 rtl/accum_shift_ctrl.sv | 139 +++++++++++++
 tb/tb_accum_shift_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_shift_ctrl.sv
// Purpose: sequences one accumulator operation (load/clear/set/shift/rotate)
//          per accepted request into per-cycle commands for the shift register.
// Ports  : i_clk/i_clr (sync active-high reset); i_req/i_op/i_amount/i_fill_in
//          request side; i_reg_q live register value; o_ack/o_busy/o_done
//          handshake; o_reg_* drive the register's clr/set/ctrl/num_shift/Ls/Rs.
// Latency: accept at T, EXEC T+1..T+k, done pulse at T+k+1, next accept >= T+k+2.
// Backpressure: o_ack only in IDLE; requester holds i_req until o_ack.
module accum_shift_ctrl #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_req,
  input  logic [2:0]   i_op,
  input  logic [2:0]   i_amount,
  input  logic         i_fill_in,
  input  logic [N-1:0] i_reg_q,
  output logic         o_ack,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_reg_clr_n,
  output logic         o_reg_set_n,
  output logic [1:0]   o_reg_ctrl,
  output logic [2:0]   o_reg_num_shift,
  output logic         o_reg_ls,
  output logic         o_reg_rs
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SET   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;
  localparam logic [1:0] CTRL_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_op;
  logic [2:0] r_cnt;
  logic [2:0] w_k;
  logic       w_ack;

  // Number of register commands the requested op needs.
  always_comb begin
    w_k = 3'd0;
    case (i_op)
      OP_LOAD, OP_CLEAR, OP_SET:      w_k = 3'd1;
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: w_k = i_amount;
      default:                        w_k = 3'd0;
    endcase
  end

  assign w_ack = (r_state == S_IDLE) && i_req && !i_clr;

  // State register; op and step count are captured only at acceptance.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      if (w_ack) begin
        r_op  <= i_op;
        r_cnt <= w_k;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_ack) w_next_state = (w_k != 3'd0) ? S_EXEC : S_DONE;
      S_EXEC: if (r_cnt == 3'd1) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs. Commands are suppressed while i_clr is high so an aborted op
  // does not apply a step at the reset edge. Rotate fill bits come straight
  // from the live register so each step sees the previous step's result.
  always_comb begin
    o_ack           = w_ack;
    o_busy          = (r_state == S_EXEC) || (r_state == S_DONE);
    o_done          = (r_state == S_DONE) && !i_clr;
    o_reg_clr_n     = 1'b1;
    o_reg_set_n     = 1'b1;
    o_reg_ctrl      = CTRL_HOLD;
    o_reg_num_shift = 3'd0;
    o_reg_ls        = 1'b0;
    o_reg_rs        = 1'b0;
    if ((r_state == S_EXEC) && !i_clr) begin
      case (r_op)
        OP_LOAD:  o_reg_ctrl = CTRL_LOAD;
        OP_CLEAR: o_reg_clr_n = 1'b0;
        OP_SET:   o_reg_set_n = 1'b0;
        OP_SHL: begin
          o_reg_ctrl      = CTRL_LEFT;
          o_reg_num_shift = 3'd1;
          o_reg_ls        = i_fill_in;
        end
        OP_SHR: begin
          o_reg_ctrl      = CTRL_RIGHT;
          o_reg_num_shift = 3'd1;
          o_reg_rs        = i_fill_in;
        end
        OP_ROL: begin
          o_reg_ctrl      = CTRL_LEFT;
          o_reg_num_shift = 3'd1;
          o_reg_ls        = i_reg_q[N-1];
        end
        OP_ROR: begin
          o_reg_ctrl      = CTRL_RIGHT;
          o_reg_num_shift = 3'd1;
          o_reg_rs        = i_reg_q[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_shift_ctrl.sv
// Bench for accum_shift_ctrl: a behavioural accumulator register closes the
// loop; expected results are queued when each request is driven and checked
// against the register value, latency and command count at the done pulse.
module tb_accum_shift_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] amount = 3'd0;
  logic       fill_in = 1'b0;
  logic [7:0] acc = 8'h00;
  logic [7:0] reg_in = 8'h00;
  logic       o_ack, o_busy, o_done, o_reg_clr_n, o_reg_set_n, o_reg_ls, o_reg_rs;
  logic [1:0] o_reg_ctrl;
  logic [2:0] o_reg_num_shift;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  accum_shift_ctrl #(.N(8)) dut (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_op(op), .i_amount(amount),
    .i_fill_in(fill_in), .i_reg_q(acc), .o_ack(o_ack), .o_busy(o_busy),
    .o_done(o_done), .o_reg_clr_n(o_reg_clr_n), .o_reg_set_n(o_reg_set_n),
    .o_reg_ctrl(o_reg_ctrl), .o_reg_num_shift(o_reg_num_shift),
    .o_reg_ls(o_reg_ls), .o_reg_rs(o_reg_rs)
  );

  // Behavioural 8-bit accumulator register driven by the sequencer.
  function automatic logic [7:0] shift_l(input logic [7:0] v, input logic [2:0] s, input logic b);
    for (int i = 0; i < int'(s); i++) v = {v[6:0], b};
    return v;
  endfunction
  function automatic logic [7:0] shift_r(input logic [7:0] v, input logic [2:0] s, input logic b);
    for (int i = 0; i < int'(s); i++) v = {b, v[7:1]};
    return v;
  endfunction

  always @(posedge clk) begin
    if (!o_reg_clr_n)      acc <= 8'h00;
    else if (!o_reg_set_n) acc <= 8'hFF;
    else begin
      case (o_reg_ctrl)
        2'b01:   acc <= reg_in;
        2'b10:   acc <= shift_l(acc, o_reg_num_shift, o_reg_ls);
        2'b11:   acc <= shift_r(acc, o_reg_num_shift, o_reg_rs);
        default: acc <= acc;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct { logic [7:0] q; int k; } sb_t;
  sb_t sbq[$];

  int cyc = 0;
  int t_acc = 0;
  int cmds = 0;

  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (!clr) begin
      check("ack_busy_exclusive", {31'd0, o_ack & o_busy}, 32'd0);
      if (!o_busy)
        check("idle_cmd", {22'd0, o_reg_clr_n, o_reg_set_n, o_reg_ctrl, o_reg_num_shift, o_reg_ls, o_reg_rs},
              {22'd0, 10'b11_00_000_0_0});
      if (o_ack) begin
        t_acc = cyc;
        cmds  = 0;
      end
      if (o_reg_ctrl != 2'b00 || !o_reg_clr_n || !o_reg_set_n) begin
        cmds++;
        if (o_reg_ctrl[1]) check("num_shift_one", {29'd0, o_reg_num_shift}, 32'd1);
      end
      if (o_done) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("result_q", {24'd0, acc}, {24'd0, e.q});
          check("done_latency", cyc - t_acc, e.k + 1);
          check("cmd_count", cmds, e.k);
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_done && n < 50);
    if (!o_done) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [2:0] a, input logic f,
                       input logic [7:0] d, input logic [7:0] eq, input int ek);
    sb_t e;
    int n = 0;
    @(posedge clk); #1;
    e.q = eq; e.k = ek;
    sbq.push_back(e);
    op = o; amount = a; fill_in = f; reg_in = d; req = 1'b1;
    do begin @(negedge clk); n++; end while (!o_ack && n < 50);
    if (!o_ack) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack", n);
    end
    @(posedge clk); #1;
    req = 1'b0;
    // Later changes to op/amount must not affect the accepted op.
    op = ~o; amount = ~a;
    wait_done();
  endtask

  typedef struct {
    logic [7:0] start; logic [2:0] op; logic [2:0] amt; logic fill;
    logic [7:0] din;   logic [7:0] exp_q; int exp_k;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int n;
    vecs[0]  = '{8'h00, 3'b001, 3'd0, 1'b0, 8'hA5, 8'hA5, 1}; // LOAD A5
    vecs[1]  = '{8'h81, 3'b110, 3'd3, 1'b0, 8'h81, 8'h0C, 3}; // ROL 3
    vecs[2]  = '{8'h81, 3'b111, 3'd1, 1'b0, 8'h81, 8'hC0, 1}; // ROR 1
    vecs[3]  = '{8'hF0, 3'b101, 3'd4, 1'b0, 8'hF0, 8'h0F, 4}; // SHR 4 fill 0
    vecs[4]  = '{8'h3C, 3'b100, 3'd2, 1'b1, 8'h3C, 8'hF3, 2}; // SHL 2 fill 1
    vecs[5]  = '{8'h5A, 3'b111, 3'd7, 1'b0, 8'h5A, 8'hB4, 7}; // ROR 7
    vecs[6]  = '{8'h96, 3'b110, 3'd7, 1'b1, 8'h96, 8'h4B, 7}; // ROL 7
    vecs[7]  = '{8'h0F, 3'b100, 3'd0, 1'b1, 8'h0F, 8'h0F, 0}; // SHL 0
    vecs[8]  = '{8'h33, 3'b000, 3'd5, 1'b1, 8'h33, 8'h33, 0}; // NOP
    vecs[9]  = '{8'h12, 3'b010, 3'd3, 1'b0, 8'h12, 8'h00, 1}; // CLEAR
    vecs[10] = '{8'h12, 3'b011, 3'd3, 1'b0, 8'h12, 8'hFF, 1}; // SET
    vecs[11] = '{8'h01, 3'b101, 3'd3, 1'b1, 8'h01, 8'hE0, 3}; // SHR 3 fill 1
    vecs[12] = '{8'hC3, 3'b001, 3'd6, 1'b0, 8'h5C, 8'h5C, 1}; // LOAD over C3

    // Reset with req and clr both high: clr wins.
    clr = 1'b1; req = 1'b1; op = 3'b001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ack", {31'd0, o_ack}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_cmd", {22'd0, o_reg_clr_n, o_reg_set_n, o_reg_ctrl, o_reg_num_shift, o_reg_ls, o_reg_rs},
          {22'd0, 10'b11_00_000_0_0});
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(3'b001, 3'd0, 1'b0, vecs[i].start, vecs[i].start, 1);
      do_op(vecs[i].op, vecs[i].amt, vecs[i].fill, vecs[i].din, vecs[i].exp_q, vecs[i].exp_k);
    end

    // Second request held during busy: accepted only at T+k+2.
    do_op(3'b001, 3'd0, 1'b0, 8'h81, 8'h81, 1);
    @(posedge clk); #1;
    sbq.push_back('{8'h06, 2});
    op = 3'b110; amount = 3'd2; fill_in = 1'b0; req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ack && n < 50);
    check("held_first_ack", {31'd0, o_ack}, 32'd1);
    @(posedge clk); #1;
    sbq.push_back('{8'h83, 1});
    op = 3'b101; amount = 3'd1; fill_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ack && n < 50);
    check("held_second_ack_delay", n, 4);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();

    // Reset in the 2nd EXEC cycle of a 5-step SHL: abort after one step.
    do_op(3'b001, 3'd0, 1'b0, 8'h81, 8'h81, 1);
    @(posedge clk); #1;
    op = 3'b100; amount = 3'd5; fill_in = 1'b0; req = 1'b1;
    @(negedge clk);
    check("abort_ack", {31'd0, o_ack}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    check("abort_cmd_during_clr", {30'd0, o_reg_ctrl}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_q", {24'd0, acc}, 32'h02);
    repeat (4) @(negedge clk);
    check("abort_no_done_q", {24'd0, acc}, 32'h02);
    check("abort_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
